// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path: FSM states,
// RAM opcodes and the opcode check for each payload state.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA,
        WAIT_TX,
        SEND,
        DONE
    } state_e;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    localparam int FRAME_BITS = 10;

    // A frame is accepted only when its opcode agrees with the path chosen by the command bit.
    function automatic logic opcode_ok(input state_e st, input logic [1:0] op);
        case (st)
            WRITE:     return (op == OP_WR_ADDR) || (op == OP_WR_DATA);
            READ_ADD:  return op == OP_RD_ADDR;
            READ_DATA: return op == OP_RD_DATA;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_tx_ser.sv
// Load/shift serialiser for the MISO reply; the MSB flop drives MISO directly
// so the output is registered and reads 0 once all bits are shifted out.
module spi_tx_ser #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         shift_i,
    input  logic         clear_i,
    output logic         bit_o,
    output logic         done_o
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [W-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (load_i) begin
            shift_d = data_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shift_d = {shift_q[W-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o  = shift_q[W-1];
    assign done_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/spi_slave_rx.sv
// SPI slave front end of the single-port RAM: deserialises command frames into
// RAM words and serialises the RAM read reply on MISO.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int RX_W = DATA_W + 2;
    localparam int BW   = $clog2(RX_W);
    localparam int TW   = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(RX_W - 1);
    localparam logic [TW-1:0] TX_LAST  = TW'(TX_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RX_W-2:0] rx_shift_q, rx_shift_d;
    logic [RX_W-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            rd_addr_done_q, rd_addr_done_d;
    logic [TW-1:0]   tx_cnt_q, tx_cnt_d;

    logic            ser_load, ser_shift, ser_clear;
    logic            ser_bit, ser_done;
    logic [RX_W-1:0] rx_word;

    // Word as it stands once the bit currently on MOSI is included.
    assign rx_word = {rx_shift_q, MOSI};

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        frame_err_d    = 1'b0;
        rd_addr_done_d = rd_addr_done_q;
        tx_cnt_d       = tx_cnt_q;
        ser_load       = 1'b0;
        ser_shift      = 1'b0;
        ser_clear      = 1'b0;

        if (SS_n) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            rx_shift_d = '0;
            tx_cnt_d   = '0;
            ser_clear  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = CHK_CMD;
                    bit_cnt_d = '0;
                end
                CHK_CMD: begin
                    if (!MOSI)               state_d = WRITE;
                    else if (rd_addr_done_q) state_d = READ_DATA;
                    else                     state_d = READ_ADD;
                end
                WRITE, READ_ADD, READ_DATA: begin
                    rx_shift_d = rx_word[RX_W-2:0];
                    bit_cnt_d  = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (opcode_ok(state_q, rx_word[RX_W-1 -: 2])) begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                            state_d    = DONE;
                            if (state_q == READ_ADD) begin
                                rd_addr_done_d = 1'b1;
                            end else if (state_q == READ_DATA) begin
                                rd_addr_done_d = 1'b0;
                                tx_cnt_d       = '0;
                                state_d        = WAIT_TX;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = DONE;
                        end
                    end
                end
                WAIT_TX: begin
                    if (tx_valid) begin
                        ser_load = 1'b1;
                        tx_cnt_d = '0;
                        state_d  = SEND;
                    end else if (tx_cnt_q == TX_LAST) begin
                        frame_err_d = 1'b1;
                        tx_cnt_d    = '0;
                        state_d     = DONE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + TW'(1);
                    end
                end
                SEND: begin
                    ser_shift = 1'b1;
                    if (ser_done) state_d = DONE;
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            rd_addr_done_q <= 1'b0;
            tx_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            frame_err_q    <= frame_err_d;
            rd_addr_done_q <= rd_addr_done_d;
            tx_cnt_q       <= tx_cnt_d;
        end
    end

    spi_tx_ser #(
        .W(DATA_W)
    ) u_tx_ser (
        .clk    (clk),
        .rst    (rst),
        .load_i (ser_load),
        .data_i (tx_data),
        .shift_i(ser_shift),
        .clear_i(ser_clear),
        .bit_o  (ser_bit),
        .done_o (ser_done)
    );

    assign MISO      = ser_bit;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a table of whole frames checked cycle by
// cycle, plus hand sequences for abort and reset in the middle of a reply.
module tb_spi_slave_rx;
    import spi_pkg::*;

    localparam int LAST_C = 25;

    logic       clk = 1'b0;
    logic       rst;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    logic [9:0] last_rx;

    typedef struct {
        string      name;
        logic       cmd;
        logic [9:0] payload;
        int         tx_cycle;
        logic [7:0] tx_byte;
        bit         miso_on;
        int         rv_cycle;
        logic [9:0] rx_exp;
        int         fe_cycle;
        logic       exp_rd;
    } vec_t;

    vec_t vecs[16];

    spi_slave_rx #(
        .DATA_W(8),
        .TX_TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    // Inputs for cycle c of a frame: c=0 SS_n low, c=1 command bit, c=2..11 payload MSB-first.
    task automatic drive_cycle(input int c, input vec_t v);
        int idx;
        SS_n = 1'b0;
        if (c == 1) begin
            MOSI = v.cmd;
        end else if (c >= 2 && c <= 1 + FRAME_BITS) begin
            idx  = 1 + FRAME_BITS - c;
            MOSI = v.payload[idx];
        end else begin
            MOSI = (c == 0) ? 1'b0 : 1'b1;
        end
        tx_valid = (v.tx_cycle != 0) && (c == v.tx_cycle);
        tx_data  = v.tx_byte;
    endtask

    task automatic run_frame(input vec_t v);
        logic       exp_rv, exp_fe, exp_miso;
        logic [9:0] exp_rx;
        int         bidx;
        for (int c = 0; c <= LAST_C; c++) begin
            exp_rv = (v.rv_cycle != 0) && (c == v.rv_cycle);
            exp_fe = (v.fe_cycle != 0) && (c == v.fe_cycle);
            exp_rx = (v.rv_cycle != 0 && c >= v.rv_cycle) ? v.rx_exp : last_rx;
            exp_miso = 1'b0;
            if (v.miso_on && c > v.tx_cycle && c <= v.tx_cycle + 8) begin
                bidx     = 7 - (c - v.tx_cycle - 1);
                exp_miso = v.tx_byte[bidx];
            end
            check($sformatf("%s_rv_c%0d", v.name, c), 32'(rx_valid), 32'(exp_rv));
            check($sformatf("%s_fe_c%0d", v.name, c), 32'(frame_err), 32'(exp_fe));
            check($sformatf("%s_rx_c%0d", v.name, c), 32'(rx_data), 32'(exp_rx));
            check($sformatf("%s_miso_c%0d", v.name, c), 32'(MISO), 32'(exp_miso));
            drive_cycle(c, v);
            cycle_end();
        end
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        cycle_end();
        if (v.rv_cycle != 0) last_rx = v.rx_exp;
        check({v.name, "_idle"}, 32'(dut.state_q), 32'(IDLE));
        check({v.name, "_rd_flag"}, 32'(dut.rd_addr_done_q), 32'(v.exp_rd));
        check({v.name, "_rx_hold"}, 32'(rx_data), 32'(last_rx));
        cycle_end();
    endtask

    initial begin
        vec_t abort_v, ra_v, rd_v, wr_v;

        vecs[0]  = '{"wr_addr",  1'b0, 10'h0A5, 0,  8'h00, 1'b0, 12, 10'h0A5, 0,  1'b0};
        vecs[1]  = '{"wr_data",  1'b0, 10'h13C, 0,  8'h00, 1'b0, 12, 10'h13C, 0,  1'b0};
        vecs[2]  = '{"rd_addr",  1'b1, 10'h207, 0,  8'h00, 1'b0, 12, 10'h207, 0,  1'b1};
        vecs[3]  = '{"rd_data",  1'b1, 10'h3A5, 13, 8'hC3, 1'b1, 12, 10'h3A5, 0,  1'b0};
        vecs[4]  = '{"wr_after", 1'b0, 10'h155, 0,  8'h00, 1'b0, 12, 10'h155, 0,  1'b0};
        vecs[5]  = '{"bad_ra",   1'b1, 10'h301, 0,  8'h00, 1'b0, 0,  10'h000, 12, 1'b0};
        vecs[6]  = '{"rd_addr2", 1'b1, 10'h2FF, 0,  8'h00, 1'b0, 12, 10'h2FF, 0,  1'b1};
        vecs[7]  = '{"rd_tmo",   1'b1, 10'h300, 0,  8'h00, 1'b0, 12, 10'h300, 16, 1'b0};
        vecs[8]  = '{"bad_wr",   1'b0, 10'h201, 0,  8'h00, 1'b0, 0,  10'h000, 12, 1'b0};
        vecs[9]  = '{"wr_stray", 1'b0, 10'h0F0, 12, 8'hAA, 1'b0, 12, 10'h0F0, 0,  1'b0};
        vecs[10] = '{"rd_addr3", 1'b1, 10'h2AA, 0,  8'h00, 1'b0, 12, 10'h2AA, 0,  1'b1};
        vecs[11] = '{"rd_late",  1'b1, 10'h3FF, 15, 8'h5A, 1'b1, 12, 10'h3FF, 0,  1'b0};
        vecs[12] = '{"rd_addr4", 1'b1, 10'h200, 0,  8'h00, 1'b0, 12, 10'h200, 0,  1'b1};
        vecs[13] = '{"wr_keep",  1'b0, 10'h0AB, 0,  8'h00, 1'b0, 12, 10'h0AB, 0,  1'b1};
        vecs[14] = '{"bad_rd",   1'b1, 10'h2C3, 0,  8'h00, 1'b0, 0,  10'h000, 12, 1'b1};
        vecs[15] = '{"rd_tmo2",  1'b1, 10'h3C3, 0,  8'h00, 1'b0, 12, 10'h3C3, 16, 1'b0};

        rst      = 1'b1;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        last_rx  = 10'h000;

        #12;
        check("rst_state",     32'(dut.state_q), 32'(IDLE));
        check("rst_miso",      32'(MISO), 32'd0);
        check("rst_rx_data",   32'(rx_data), 32'd0);
        check("rst_rx_valid",  32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_rd_flag",   32'(dut.rd_addr_done_q), 32'd0);
        #2 rst = 1'b0;
        cycle_end();
        cycle_end();

        for (int i = 0; i < 16; i++) run_frame(vecs[i]);

        // Abort a write after five payload bits; the link must settle in IDLE.
        abort_v = '{"abort", 1'b0, 10'h3FF, 0, 8'h00, 1'b0, 0, 10'h000, 0, 1'b0};
        for (int c = 0; c <= 6; c++) begin
            drive_cycle(c, abort_v);
            cycle_end();
        end
        SS_n = 1'b1;
        cycle_end();
        check("abort_idle",    32'(dut.state_q), 32'(IDLE));
        check("abort_bit_cnt", 32'(dut.bit_cnt_q), 32'd0);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("abort_rv_%0d", c), 32'(rx_valid), 32'd0);
            check($sformatf("abort_fe_%0d", c), 32'(frame_err), 32'd0);
            cycle_end();
        end
        check("abort_rd_flag", 32'(dut.rd_addr_done_q), 32'd0);
        wr_v = '{"post_abort", 1'b0, 10'h03C, 0, 8'h00, 1'b0, 12, 10'h03C, 0, 1'b0};
        run_frame(wr_v);

        // Reset asserted while the reply is on MISO.
        ra_v = '{"rst_ra", 1'b1, 10'h211, 0, 8'h00, 1'b0, 12, 10'h211, 0, 1'b1};
        run_frame(ra_v);
        rd_v = '{"rst_rd", 1'b1, 10'h3A5, 13, 8'hFF, 1'b1, 12, 10'h3A5, 0, 1'b0};
        for (int c = 0; c <= 15; c++) begin
            drive_cycle(c, rd_v);
            cycle_end();
        end
        check("send_state", 32'(dut.state_q), 32'(SEND));
        check("send_miso",  32'(MISO), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_miso",     32'(MISO), 32'd0);
        check("midrst_state",    32'(dut.state_q), 32'(IDLE));
        check("midrst_rd_flag",  32'(dut.rd_addr_done_q), 32'd0);
        check("midrst_rx_data",  32'(rx_data), 32'd0);
        check("midrst_rx_valid", 32'(rx_valid), 32'd0);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rx = 10'h000;
        cycle_end();
        wr_v = '{"post_rst", 1'b0, 10'h0C3, 0, 8'h00, 1'b0, 12, 10'h0C3, 0, 1'b0};
        run_frame(wr_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
